avmm_csr_arbiter: RTL and testbench
===================================

Name: avmm_csr_arbiter

Overview:
- Two-master round-robin arbiter that shares one Avalon-MM CSR slave, such as the AFU ID/DFH register block, between the host MMIO path (m0) and an internal requester (m1, e.g. DMA or debug).
- The slave has no waitrequest and returns readdata a fixed READ_LATENCY cycles after a read.
- The arbiter adds waitrequest/readdatavalid handshaking toward the masters and routes each read response back to the master that issued it.

Parameters:
- DATA_WIDTH, 64, data width of all data ports
- ADDR_WIDTH, 3, word address width of all address ports
- READ_LATENCY, 1, fixed slave read latency in cycles; legal range 1..4

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m0_address / m1_address  in  ADDR_WIDTH  master word address
- m0_read / m1_read  in  1  read request
- m0_write / m1_write  in  1  write request
- m0_writedata / m1_writedata  in  DATA_WIDTH  write data
- m0_waitrequest / m1_waitrequest  out  1  high = command not accepted this cycle
- m0_readdata / m1_readdata  out  DATA_WIDTH  read response data
- m0_readdatavalid / m1_readdatavalid  out  1  one-cycle read response strobe
- s_address  out  ADDR_WIDTH  slave address
- s_read  out  1  slave read strobe
- s_write  out  1  slave write strobe
- s_writedata  out  DATA_WIDTH  slave write data
- s_readdata  in  DATA_WIDTH  slave read data, valid READ_LATENCY cycles after s_read
- err_rw_both  out  1  sticky flag: a master asserted read and write in the same cycle

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Request: req_i = mi_read | mi_write.
- Grant (combinational, one master per cycle):
  - Only one master requesting: that master is granted.
  - Both requesting: grant goes to the master not granted last (last_grant pointer).
  - last_grant updates only on a grant.
  - Reset value of last_grant = 1, so m0 wins the first contention.
- Waitrequest:
  - mi_waitrequest = reset | !grant_i.
  - Non-requesting masters also see waitrequest = 1.
  - Masters hold address, data and strobes stable while waitrequest = 1 (Avalon rule; not checked).
- Command stage (registered):
  - A command accepted in cycle T drives s_address/s_read/s_write/s_writedata in cycle T+1.
  - With no grant, s_read = s_write = 0; s_address and s_writedata hold their last values.
  - Throughput is 1 command per cycle; back-to-back grants are allowed.
- Read and write asserted together by one master:
  - Forwarded as a write only; no read response is generated.
  - err_rw_both is set and stays set until reset.
- Response tracking:
  - Shift register of READ_LATENCY+1 entries {valid, master_id}, loaded when s_read issues.
  - Slave data sampled in cycle T+1+READ_LATENCY.
  - mi_readdata / mi_readdatavalid registered and asserted in cycle T+2+READ_LATENCY.
  - Total read latency from acceptance = READ_LATENCY+2 cycles.
  - Responses return strictly in issue order.
- Readdata routing:
  - mi_readdata updates only with its own readdatavalid and otherwise holds.
  - The non-target master's readdata is unchanged.
- Reset values: s_read = s_write = 0, s_address = 0, s_writedata = 0, all readdatavalid = 0, all readdata = 0, err_rw_both = 0, tracker empty.
- Reset mid-operation:
  - Commands and pending reads in flight are discarded.
  - No readdatavalid is asserted for them after reset deasserts.
  - Waitrequest stays high through the reset cycle(s).
- No outstanding-read limit is needed: the slave is fully pipelined with fixed latency.

Test Plan:
- m0 read addr 1 alone (READ_LATENCY=1), slave returns 64'h9081_F88B_8F65_5CAA -> m0_waitrequest low in T, s_read in T+1, m0_readdatavalid with that data in T+3, m1 outputs unchanged.
- m0 and m1 both hold reads (addr 1, addr 2) for 4 cycles, both re-requesting after each grant:
  - grants alternate m0, m1, m0, m1;
  - responses return in that order, each routed to its issuing master.
- m1 write addr 5 data 64'hDEAD_BEEF, then m0 read addr 5 in the next cycle -> s_write precedes s_read by 1 cycle; m0 receives the slave's addr-5 data.
- m0 asserts read+write addr 5 -> single s_write, no readdatavalid, err_rw_both = 1 and held until reset.
- Reset asserted the cycle after an m1 read is accepted -> m1_readdatavalid never asserts, all outputs at reset values, next contention grants m0 first.
- READ_LATENCY=4, 4 back-to-back reads alternating masters -> 4 readdatavalid pulses on consecutive cycles starting at T+6, correct master per pulse.

Source files
------------

// File: rtl/avmm_csr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : avmm_csr_arbiter
//  Purpose  : Two-master round-robin arbiter in front of a single Avalon-MM
//             CSR slave that has no waitrequest and a fixed read latency.
//             Adds waitrequest/readdatavalid handshaking toward the masters
//             and steers each read response back to the master that issued it.
//  Ports    : clk, reset                  - clock, synchronous active-high reset
//             m0_* / m1_*                 - Avalon-MM master-side ports
//                                           (address, read, write, writedata in;
//                                            waitrequest, readdata,
//                                            readdatavalid out)
//             s_*                         - Avalon-MM slave-side ports
//             err_rw_both                 - sticky read+write-together flag
//  Revision : 1.0 - initial release
// ============================================================================
module avmm_csr_arbiter #(
    parameter int DATA_WIDTH   = 64,
    parameter int ADDR_WIDTH   = 3,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdatavalid,

    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdatavalid,

    output logic [ADDR_WIDTH-1:0] s_address,
    output logic                  s_read,
    output logic                  s_write,
    output logic [DATA_WIDTH-1:0] s_writedata,
    input  logic [DATA_WIDTH-1:0] s_readdata,

    output logic                  err_rw_both
);

    // One tracker slot per cycle between acceptance and slave data sampling.
    localparam int TRK_DEPTH = READ_LATENCY + 1;

    // ------------------------------------------------------------------
    // Grant logic
    // ------------------------------------------------------------------
    logic                  req0;
    logic                  req1;
    logic                  grant0;
    logic                  grant1;
    logic                  any_grant;
    logic [ADDR_WIDTH-1:0] sel_address;
    logic [DATA_WIDTH-1:0] sel_writedata;
    logic                  sel_read;
    logic                  sel_write;
    logic                  issue_read;

    // Pointer to the master granted most recently (0 = m0, 1 = m1).
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        req0          = m0_read | m0_write;
        req1          = m1_read | m1_write;
        grant0        = 1'b0;
        grant1        = 1'b0;
        if (!reset) begin
            // m0 wins when alone, or on contention when m1 was served last.
            if (req0 && (!req1 || last_grant_q)) begin
                grant0 = 1'b1;
            end else if (req1) begin
                grant1 = 1'b1;
            end
        end
        any_grant     = grant0 | grant1;
        sel_address   = grant1 ? m1_address   : m0_address;
        sel_writedata = grant1 ? m1_writedata : m0_writedata;
        sel_read      = grant1 ? m1_read      : m0_read;
        sel_write     = grant1 ? m1_write     : m0_write;
        // Read+write together is forwarded as a write only.
        issue_read    = any_grant & sel_read & ~sel_write;
        last_grant_d  = any_grant ? grant1 : last_grant_q;
    end

    assign m0_waitrequest = reset | ~grant0;
    assign m1_waitrequest = reset | ~grant1;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // ------------------------------------------------------------------
    // Command stage
    // ------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] s_address_q;
    logic                  s_read_q;
    logic                  s_write_q;
    logic [DATA_WIDTH-1:0] s_writedata_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s_address_q   <= '0;
            s_read_q      <= 1'b0;
            s_write_q     <= 1'b0;
            s_writedata_q <= '0;
        end else begin
            s_read_q  <= issue_read;
            s_write_q <= any_grant & sel_write;
            // Address/data hold their last values on idle cycles.
            if (any_grant) begin
                s_address_q   <= sel_address;
                s_writedata_q <= sel_writedata;
            end
        end
    end

    assign s_address   = s_address_q;
    assign s_read      = s_read_q;
    assign s_write     = s_write_q;
    assign s_writedata = s_writedata_q;

    // ------------------------------------------------------------------
    // Sticky read+write error flag
    // ------------------------------------------------------------------
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_q | (m0_read & m0_write) | (m1_read & m1_write);
        end
    end

    assign err_rw_both = err_q;

    // ------------------------------------------------------------------
    // Response tracker: slot k holds the read issued k+1 cycles ago, so
    // slot READ_LATENCY lines up with valid slave data.
    // ------------------------------------------------------------------
    logic [TRK_DEPTH-1:0] trk_vld_q;
    logic [TRK_DEPTH-1:0] trk_id_q;
    logic                 rsp_vld;
    logic                 rsp_id;

    always_ff @(posedge clk) begin
        if (reset) begin
            trk_vld_q <= '0;
            trk_id_q  <= '0;
        end else begin
            trk_vld_q <= {trk_vld_q[TRK_DEPTH-2:0], issue_read};
            trk_id_q  <= {trk_id_q[TRK_DEPTH-2:0],  grant1};
        end
    end

    assign rsp_vld = trk_vld_q[READ_LATENCY];
    assign rsp_id  = trk_id_q[READ_LATENCY];

    // ------------------------------------------------------------------
    // Response registers; each readdata only moves with its own strobe.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] m0_readdata_q;
    logic [DATA_WIDTH-1:0] m1_readdata_q;
    logic                  m0_rdv_q;
    logic                  m1_rdv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            m0_readdata_q <= '0;
            m1_readdata_q <= '0;
            m0_rdv_q      <= 1'b0;
            m1_rdv_q      <= 1'b0;
        end else begin
            m0_rdv_q <= rsp_vld & ~rsp_id;
            m1_rdv_q <= rsp_vld &  rsp_id;
            if (rsp_vld && !rsp_id) begin
                m0_readdata_q <= s_readdata;
            end
            if (rsp_vld && rsp_id) begin
                m1_readdata_q <= s_readdata;
            end
        end
    end

    assign m0_readdata      = m0_readdata_q;
    assign m1_readdata      = m1_readdata_q;
    assign m0_readdatavalid = m0_rdv_q;
    assign m1_readdatavalid = m1_rdv_q;

endmodule
`default_nettype wire

// File: tb/tb_avmm_csr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_avmm_csr_arbiter
//  Purpose  : Self-checking bench for avmm_csr_arbiter. One instance runs with
//             READ_LATENCY=1, a second with READ_LATENCY=4. Each has a small
//             fixed-latency slave memory model; read expectations are pushed
//             to a per-instance queue on acceptance and popped when a
//             readdatavalid strobe appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_avmm_csr_arbiter;

    localparam int RL1 = 1;
    localparam int RL4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A (READ_LATENCY = 1) ----------------
    logic        reset;
    logic [2:0]  m0_address, m1_address;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [63:0] m0_writedata, m1_writedata;
    logic        m0_waitrequest, m1_waitrequest;
    logic [63:0] m0_readdata, m1_readdata;
    logic        m0_readdatavalid, m1_readdatavalid;
    logic [2:0]  s_address;
    logic        s_read, s_write;
    logic [63:0] s_writedata, s_readdata;
    logic        err_rw_both;

    avmm_csr_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .READ_LATENCY(RL1)) dut1 (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
        .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
        .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_readdata(s_readdata),
        .err_rw_both(err_rw_both)
    );

    // ---------------- instance B (READ_LATENCY = 4) ----------------
    logic        reset4;
    logic [2:0]  p0_address, p1_address;
    logic        p0_read, p0_write, p1_read, p1_write;
    logic [63:0] p0_writedata, p1_writedata;
    logic        p0_waitrequest, p1_waitrequest;
    logic [63:0] p0_readdata, p1_readdata;
    logic        p0_readdatavalid, p1_readdatavalid;
    logic [2:0]  s4_address;
    logic        s4_read, s4_write;
    logic [63:0] s4_writedata, s4_readdata;
    logic        err4;

    avmm_csr_arbiter #(.DATA_WIDTH(64), .ADDR_WIDTH(3), .READ_LATENCY(RL4)) dut4 (
        .clk(clk), .reset(reset4),
        .m0_address(p0_address), .m0_read(p0_read), .m0_write(p0_write),
        .m0_writedata(p0_writedata), .m0_waitrequest(p0_waitrequest),
        .m0_readdata(p0_readdata), .m0_readdatavalid(p0_readdatavalid),
        .m1_address(p1_address), .m1_read(p1_read), .m1_write(p1_write),
        .m1_writedata(p1_writedata), .m1_waitrequest(p1_waitrequest),
        .m1_readdata(p1_readdata), .m1_readdatavalid(p1_readdatavalid),
        .s_address(s4_address), .s_read(s4_read), .s_write(s4_write),
        .s_writedata(s4_writedata), .s_readdata(s4_readdata),
        .err_rw_both(err4)
    );

    // ---------------- slave models ----------------
    function automatic logic [63:0] init_word(int i);
        if (i == 1) return 64'h9081_F88B_8F65_5CAA;
        return {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i * 17)};
    endfunction

    localparam logic [63:0] JUNK = 64'hBADD_BADD_BADD_BADD;

    logic [63:0] smem1 [8];
    logic [63:0] smem4 [8];
    logic [63:0] sp1;
    logic [63:0] sp4 [4];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 8; i++) begin
                smem1[i] <= init_word(i);
                smem4[i] <= init_word(i);
            end
        end else begin
            if (s_write)  smem1[s_address]  <= s_writedata;
            if (s4_write) smem4[s4_address] <= s4_writedata;
        end
        // Data only appears in the exact latency slot; junk elsewhere.
        sp1    <= s_read  ? smem1[s_address]  : JUNK;
        sp4[0] <= s4_read ? smem4[s4_address] : JUNK;
        for (int k = 1; k < 4; k++) sp4[k] <= sp4[k-1];
    end
    assign s_readdata  = sp1;
    assign s4_readdata = sp4[3];

    // ---------------- reference model + scoreboard ----------------
    logic [63:0] ref_mem [2][8];
    logic [63:0] exp_rd  [2][2];

    typedef struct {
        int          id;
        logic [63:0] data;
        int          due;
    } sb_t;
    sb_t sbq [2][$];

    task automatic chkb(string nm, logic act, logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %b expected %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chkd(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic push(int d, int id, logic [63:0] data, int due);
        sb_t e;
        e.id = id; e.data = data; e.due = due;
        sbq[d].push_back(e);
    endtask

    task automatic mon(int d, logic rst, logic [1:0] v, logic [63:0] rd0, logic [63:0] rd1);
        logic [63:0] rd [2];
        sb_t e;
        rd[0] = rd0;
        rd[1] = rd1;
        if (rst) begin
            sbq[d].delete();
            exp_rd[d][0] = '0;
            exp_rd[d][1] = '0;
            return;
        end
        for (int m = 0; m < 2; m++) begin
            if (v[m]) begin
                if (sbq[d].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected dut%0d m%0d @cyc %0d: readdatavalid with no read pending, data %h",
                             d, m, cyc, rd[m]);
                end else begin
                    e = sbq[d].pop_front();
                    chkd("rsp_master", 64'(m), 64'(e.id));
                    chkd("rsp_cycle", 64'(cyc), 64'(e.due));
                    chkd("rsp_data", rd[m], e.data);
                    exp_rd[d][m] = e.data;
                    chkd("rsp_hold_other", rd[1-m], exp_rd[d][1-m]);
                end
            end
        end
        if (sbq[d].size() > 0 && sbq[d][0].due < cyc) begin
            e = sbq[d].pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL rsp_missing dut%0d @cyc %0d: no readdatavalid, expected m%0d data %h at cyc %0d",
                     d, cyc, e.id, e.data, e.due);
        end
    endtask

    always @(negedge clk) begin
        mon(0, reset,  {m1_readdatavalid, m0_readdatavalid}, m0_readdata, m1_readdata);
        mon(1, reset4, {p1_readdatavalid, p0_readdatavalid}, p0_readdata, p1_readdata);
    end

    // ---------------- stimulus table (instance A) ----------------
    typedef struct {
        logic        m0r, m0w;
        logic [2:0]  m0a;
        logic        m1r, m1w;
        logic [2:0]  m1a;
        logic [63:0] wd;
        logic        w0, w1, sr, sw;
        logic [2:0]  sa;
    } vec_t;

    function automatic vec_t mk(bit m0r, bit m0w, int m0a, bit m1r, bit m1w, int m1a,
                                logic [63:0] wd, bit w0, bit w1, bit sr, bit sw, int sa);
        vec_t v;
        v.m0r = m0r; v.m0w = m0w; v.m0a = 3'(m0a);
        v.m1r = m1r; v.m1w = m1w; v.m1a = 3'(m1a);
        v.wd  = wd;
        v.w0 = w0; v.w1 = w1; v.sr = sr; v.sw = sw; v.sa = 3'(sa);
        return v;
    endfunction

    task automatic check_reset_vals(string tag);
        chkb({tag, "_sread"},  s_read, 1'b0);
        chkb({tag, "_swrite"}, s_write, 1'b0);
        chkd({tag, "_saddr"},  64'(s_address), 64'd0);
        chkd({tag, "_swdata"}, s_writedata, 64'd0);
        chkb({tag, "_rdv0"},   m0_readdatavalid, 1'b0);
        chkb({tag, "_rdv1"},   m1_readdatavalid, 1'b0);
        chkd({tag, "_rd0"},    m0_readdata, 64'd0);
        chkd({tag, "_rd1"},    m1_readdata, 64'd0);
        chkb({tag, "_err"},    err_rw_both, 1'b0);
    endtask

    vec_t tbl [18];

    initial begin
        tbl[0]  = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,0);
        tbl[1]  = mk(1,0,1, 1,0,2, 64'h0,                   0,1,1,0,1);
        tbl[2]  = mk(1,0,1, 1,0,2, 64'h0,                   1,0,1,0,2);
        tbl[3]  = mk(1,0,1, 1,0,2, 64'h0,                   0,1,1,0,1);
        tbl[4]  = mk(1,0,1, 1,0,2, 64'h0,                   1,0,1,0,2);
        tbl[5]  = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,2);
        tbl[6]  = mk(1,0,1, 0,0,0, 64'h0,                   0,1,1,0,1);
        tbl[7]  = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,1);
        tbl[8]  = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,1);
        tbl[9]  = mk(0,0,0, 0,1,5, 64'h0000_0000_DEAD_BEEF, 1,0,0,1,5);
        tbl[10] = mk(1,0,5, 0,0,0, 64'h0,                   0,1,1,0,5);
        tbl[11] = mk(1,1,5, 0,0,0, 64'h1234_5678_9ABC_DEF0, 0,1,0,1,5);
        tbl[12] = mk(0,0,0, 1,0,3, 64'h0,                   1,0,1,0,3);
        tbl[13] = mk(0,1,4, 1,0,4, 64'hCAFE_F00D_0BAD_1DEA, 0,1,0,1,4);
        tbl[14] = mk(0,0,0, 1,0,4, 64'h0,                   1,0,1,0,4);
        tbl[15] = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,4);
        tbl[16] = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,4);
        tbl[17] = mk(0,0,0, 0,0,0, 64'h0,                   1,1,0,0,4);

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) ref_mem[d][i] = init_word(i);

        // Reset with both masters requesting: waitrequest must stay high.
        reset = 1'b1; reset4 = 1'b1;
        m0_address = 3'd1; m1_address = 3'd2; m0_read = 1'b1; m1_read = 1'b1;
        m0_write = 1'b0; m1_write = 1'b0; m0_writedata = '0; m1_writedata = '0;
        p0_address = '0; p1_address = '0; p0_read = 1'b0; p1_read = 1'b0;
        p0_write = 1'b0; p1_write = 1'b0; p0_writedata = '0; p1_writedata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chkb("rst_wait0", m0_waitrequest, 1'b1);
        chkb("rst_wait1", m1_waitrequest, 1'b1);
        check_reset_vals("rst");
        chkb("rst4_rdv0", p0_readdatavalid, 1'b0);
        chkb("rst4_err", err4, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0; reset4 = 1'b0;
        m0_read = 1'b0; m1_read = 1'b0;

        // Table: one row per cycle, grant checked mid-cycle, command after the edge.
        for (int i = 0; i < 18; i++) begin
            m0_read = tbl[i].m0r; m0_write = tbl[i].m0w; m0_address = tbl[i].m0a;
            m1_read = tbl[i].m1r; m1_write = tbl[i].m1w; m1_address = tbl[i].m1a;
            m0_writedata = tbl[i].wd; m1_writedata = tbl[i].wd;
            @(negedge clk);
            chkb("t_wait0", m0_waitrequest, tbl[i].w0);
            chkb("t_wait1", m1_waitrequest, tbl[i].w1);
            if (!tbl[i].w0 && tbl[i].m0r && !tbl[i].m0w)
                push(0, 0, ref_mem[0][tbl[i].m0a], cyc + RL1 + 2);
            if (!tbl[i].w0 && tbl[i].m0w) ref_mem[0][tbl[i].m0a] = tbl[i].wd;
            if (!tbl[i].w1 && tbl[i].m1r && !tbl[i].m1w)
                push(0, 1, ref_mem[0][tbl[i].m1a], cyc + RL1 + 2);
            if (!tbl[i].w1 && tbl[i].m1w) ref_mem[0][tbl[i].m1a] = tbl[i].wd;
            @(posedge clk); #1;
            chkb("t_sread", s_read, tbl[i].sr);
            chkb("t_swrite", s_write, tbl[i].sw);
            chkd("t_saddr", 64'(s_address), 64'(tbl[i].sa));
            if (tbl[i].sw) chkd("t_swdata", s_writedata, tbl[i].wd);
        end

        // Sticky error flag from the read+write row.
        chkb("err_set", err_rw_both, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chkb("err_sticky", err_rw_both, 1'b1);

        // Reset the cycle after an m1 read is accepted.
        m1_read = 1'b1; m1_address = 3'd3;
        @(negedge clk);
        chkb("rm_wait1", m1_waitrequest, 1'b0);
        push(0, 1, ref_mem[0][3], cyc + RL1 + 2);
        @(posedge clk); #1;
        chkb("rm_sread", s_read, 1'b1);
        reset = 1'b1;
        m0_read = 1'b1; m0_address = 3'd1; m1_address = 3'd2;
        @(negedge clk);
        chkb("rm_rst_wait0", m0_waitrequest, 1'b1);
        chkb("rm_rst_wait1", m1_waitrequest, 1'b1);
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_vals("rm");
        @(negedge clk);
        chkb("rm_first_w0", m0_waitrequest, 1'b0);
        chkb("rm_first_w1", m1_waitrequest, 1'b1);
        push(0, 0, ref_mem[0][1], cyc + RL1 + 2);
        @(posedge clk); #1;
        m0_read = 1'b0;
        @(negedge clk);
        chkb("rm_second_w1", m1_waitrequest, 1'b0);
        push(0, 1, ref_mem[0][2], cyc + RL1 + 2);
        @(posedge clk); #1;
        m1_read = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        // READ_LATENCY=4: four back-to-back contended reads.
        p0_read = 1'b1; p0_address = 3'd6;
        p1_read = 1'b1; p1_address = 3'd7;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chkb("rl4_wait0", p0_waitrequest, (k % 2) != 0);
            chkb("rl4_wait1", p1_waitrequest, (k % 2) == 0);
            push(1, k % 2, ref_mem[1][(k % 2) != 0 ? 7 : 6], cyc + RL4 + 2);
            @(posedge clk); #1;
        end
        p0_read = 1'b0; p1_read = 1'b0;
        repeat (10) @(posedge clk);
        #1;

        chkd("sb0_drained", 64'(sbq[0].size()), 64'd0);
        chkd("sb1_drained", 64'(sbq[1].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
